// File: rtl/uart1_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, valid/ack output handshake.
// Flags false starts silently, framing errors as a one-cycle pulse, and overruns as a sticky bit.
module uart1_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx1,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  // START runs one count longer than half a bit: the IDLE detect cycle is part of the start bit,
  // which places every later sample CLKS_PER_BIT cycles apart from this one.
  localparam logic [CW-1:0] MID_CNT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic [2:0]           r_state;
  logic                 r_s1;
  logic                 r_s2;
  logic [CW-1:0]        r_clk_cnt;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_rx1;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_mid_tick;
  logic w_bit_tick;

  assign w_mid_tick = (r_clk_cnt == MID_CNT);
  assign w_bit_tick = (r_clk_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_s1        <= 1'b1;
      r_s2        <= 1'b1;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_rx1       <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_s1        <= serial_in;
      r_s2        <= r_s1;
      r_frame_err <= 1'b0;

      if (rx_ack && r_rx_valid) begin
        r_rx_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (!r_s2) begin
            r_state   <= START;
            r_clk_cnt <= '0;
          end
        end

        START: begin
          if (w_mid_tick) begin
            r_clk_cnt <= '0;
            if (r_s2) begin
              r_state <= IDLE;
            end else begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end

        DATA: begin
          if (w_bit_tick) begin
            r_clk_cnt <= '0;
            r_shreg   <= {r_s2, r_shreg[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end

        STOP: begin
          if (w_bit_tick) begin
            r_clk_cnt <= '0;
            if (r_s2) begin
              // Overrides the ack clear above, so a same-cycle ack hands over cleanly.
              r_rx1      <= r_shreg;
              r_rx_valid <= 1'b1;
              if (r_rx_valid && !rx_ack) begin
                r_overrun <= 1'b1;
              end
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end

        WAIT_IDLE: begin
          if (r_s2) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx1       = r_rx1;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart1_rx.sv
// Bench for uart1_rx: directed frames feed an expected-byte queue; a monitor pops and compares
// on every accepted handshake, plus direct checks of latency, flags and reset behaviour.
module tb_uart1_rx;

  localparam int unsigned Cpb = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic [7:0] rx1;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart1_rx #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .serial_in(serial_in),
    .rx1      (rx1),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0_cyc = 0;
  int rise_cyc = 0;
  int n_rise = 0;
  int fe_cyc = 0;
  int fe_pulses = 0;
  int fe_cycles = 0;
  logic v_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic ack_en = 1'b0;
  int ack_wait = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every accepted handshake must deliver the oldest expected byte.
  always @(negedge clk) begin
    if (rx_valid && rx_ack) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_byte", int'(rx1), -1);
      end else begin
        check("sb_byte", int'(rx1), int'(exp_q.pop_front()));
      end
    end
    if (rx_valid && !v_prev) begin
      rise_cyc = cyc;
      n_rise++;
    end
    v_prev = rx_valid;
    if (frame_err) fe_cycles++;
    if (frame_err && !fe_prev) begin
      fe_pulses++;
      fe_cyc = cyc;
    end
    fe_prev = frame_err;
  end

  // Automatic consumer for the random run, with a random delay under one bit time.
  always begin
    @(posedge clk);
    #2;
    if (ack_en) begin
      if (rx_ack) begin
        rx_ack = 1'b0;
      end else if (rx_valid) begin
        if (ack_wait == 0) begin
          rx_ack   = 1'b1;
          ack_wait = int'($urandom_range(0, 14));
        end else begin
          ack_wait--;
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits   = {stop, b, 1'b0};
    t0_cyc = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      tick(Cpb);
    end
  endtask

  task automatic manual_ack(input string name);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    check(name, int'(rx_valid), 0);
  endtask

  task automatic ack_at_completion();
    repeat (155) @(posedge clk);
    #1;
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
  endtask

  initial begin
    int r;
    int gap;
    logic [7:0] b;

    // 1: reset values, then 0xA4 with latency
    do_reset();
    check("rst_rx1", int'(rx1), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    tick(5);
    exp_q.push_back(8'hA4);
    send_frame(8'hA4, 1'b1);
    check("a4_latency", rise_cyc - t0_cyc, 155);
    check("a4_rx1", int'(rx1), 'hA4);
    check("a4_valid", int'(rx_valid), 1);
    check("a4_no_fe", fe_pulses, 0);
    manual_ack("a4_ack_clears");

    // 2: 4-clk glitch is a false start
    tick(3);
    serial_in = 1'b0;
    tick(4);
    serial_in = 1'b1;
    tick(2);
    check("glitch_busy_in_start", int'(busy), 1);
    tick(10);
    check("glitch_busy_drops", int'(busy), 0);
    check("glitch_valid", int'(rx_valid), 0);
    check("glitch_no_fe", fe_pulses, 0);
    check("glitch_overrun", int'(overrun), 0);

    // 3: framing error, line held low, then recovery with 0x55
    send_frame(8'h3C, 1'b0);
    tick(40);
    check("fe_pulses", fe_pulses, 1);
    check("fe_width", fe_cycles, 1);
    check("fe_latency", fe_cyc - t0_cyc, 155);
    check("fe_valid", int'(rx_valid), 0);
    check("fe_busy_wait_idle", int'(busy), 1);
    serial_in = 1'b1;
    tick(16);
    check("fe_idle_again", int'(busy), 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    check("r55_rx1", int'(rx1), 'h55);
    manual_ack("r55_ack_clears");

    // 4: back-to-back without ack -> overrun, then with ack on the completion cycle
    exp_q.push_back(8'h34);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    check("ovr_rx1", int'(rx1), 'h34);
    check("ovr_valid", int'(rx_valid), 1);
    check("ovr_set", int'(overrun), 1);
    manual_ack("ovr_ack_clears");
    tick(4);
    check("ovr_sticky", int'(overrun), 1);
    do_reset();
    check("ovr_rst_clears", int'(overrun), 0);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_frame(8'h12, 1'b1);
    fork
      send_frame(8'h34, 1'b1);
      ack_at_completion();
    join
    check("same_cycle_ack_no_ovr", int'(overrun), 0);
    check("same_cycle_ack_valid", int'(rx_valid), 1);
    check("same_cycle_ack_rx1", int'(rx1), 'h34);
    manual_ack("same_cycle_ack_clears");

    // 5: reset mid-DATA
    serial_in = 1'b0;
    tick(Cpb * 5 + 8);
    rst = 1'b1;
    serial_in = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_rx1", int'(rx1), 0);
    check("midrst_valid", int'(rx_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_overrun", int'(overrun), 0);
    r = n_rise;
    tick(200);
    check("midrst_no_valid", n_rise, r);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    check("ff_rx1", int'(rx1), 'hFF);
    manual_ack("ff_ack_clears");

    // 6: 256 random bytes, random gaps and ack delays
    r = fe_pulses;
    ack_wait = int'($urandom_range(0, 14));
    ack_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      b   = 8'($urandom);
      gap = int'($urandom_range(0, 20));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      tick(gap);
    end
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick(1);
    check("rand_drained", exp_q.size(), 0);
    check("rand_no_fe", fe_pulses, r);
    check("rand_no_overrun", int'(overrun), 0);
    ack_en = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
